// File: rtl/opo_package.sv
// Shared definitions for the window peak detector.
// Contents:
//   state_e              - FSM state encoding (IDLE, ACCUM, REPORT)
//   DEFAULT_WORD_WIDTH   - default signed sample width
//   DEFAULT_COUNT_WIDTH  - default width of the window-length configuration
package opo_package;

  localparam int DEFAULT_WORD_WIDTH  = 16;
  localparam int DEFAULT_COUNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/window_peak_detector.sv
// Window peak detector: tracks the signed maximum and minimum of a window of
// valid samples and reports them, with their peak-to-peak distance, once
// per completed window.
// Ports:
//   clk             - clock, all logic on posedge
//   rst             - asynchronous active-low reset
//   enable          - 1 = measure, 0 = idle (abandons an open window)
//   window_len      - valid samples per window, 0 treated as 1
//   sample_in       - signed sample
//   sample_in_valid - sample_in qualifier
//   max_out         - signed maximum of the last completed window
//   min_out         - signed minimum of the last completed window
//   pp_out          - unsigned max_out - min_out, one bit wider than a sample
//   result_valid    - one-cycle pulse when the outputs update
//   busy            - high while a window is open
module window_peak_detector
  import opo_package::*;
#(
  parameter int word_width  = DEFAULT_WORD_WIDTH,
  parameter int count_width = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [count_width-1:0] window_len,
  input  logic [word_width-1:0]  sample_in,
  input  logic                   sample_in_valid,
  output logic [word_width-1:0]  max_out,
  output logic [word_width-1:0]  min_out,
  output logic [word_width:0]    pp_out,
  output logic                   result_valid,
  output logic                   busy
);

  state_e                 state_q, state_d;
  logic [count_width-1:0] count_q, count_d;
  logic [count_width-1:0] len_q, len_d;
  logic [word_width-1:0]  max_q, max_d;
  logic [word_width-1:0]  min_q, min_d;
  logic [word_width-1:0]  max_out_q, max_out_d;
  logic [word_width-1:0]  min_out_q, min_out_d;
  logic [word_width:0]    pp_out_q, pp_out_d;
  logic                   result_valid_q, result_valid_d;
  logic                   busy_q, busy_d;

  logic [count_width-1:0] len_eff_s;
  logic [count_width-1:0] base_count_s;
  logic [count_width-1:0] base_len_s;
  logic [count_width-1:0] inc_count_s;
  logic                   first_s;
  logic                   done_s;
  logic [word_width-1:0]  new_max_s;
  logic [word_width-1:0]  new_min_s;
  logic [word_width:0]    pp_s;

  // Sample datapath: candidate extrema and peak-to-peak for the current sample.
  always_comb begin
    len_eff_s = (window_len == '0) ? count_width'(1) : window_len;
    // A sample arriving in REPORT opens the next window, so it is judged
    // against a zero count and the freshly latched length.
    base_count_s = (state_q == ST_REPORT) ? '0 : count_q;
    base_len_s   = (state_q == ST_REPORT) ? len_eff_s : len_q;
    inc_count_s  = base_count_s + count_width'(1);
    done_s       = (inc_count_s == base_len_s);
    first_s      = (base_count_s == '0);
    new_max_s    = (first_s || ($signed(sample_in) > $signed(max_q))) ? sample_in : max_q;
    new_min_s    = (first_s || ($signed(sample_in) < $signed(min_q))) ? sample_in : min_q;
    // Sign-extend both by one bit so full-scale max - min cannot overflow.
    pp_s = $signed({new_max_s[word_width-1], new_max_s})
         - $signed({new_min_s[word_width-1], new_min_s});
  end

  // Next-state logic for the window FSM, counters and published results.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    len_d          = len_q;
    max_d          = max_q;
    min_d          = min_q;
    max_out_d      = max_out_q;
    min_out_d      = min_out_q;
    pp_out_d       = pp_out_q;
    result_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ACCUM;
          count_d = '0;
          len_d   = len_eff_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM, ST_REPORT: begin
        if (!enable) begin
          // Abandon the open window; published results are left untouched.
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          state_d = ST_ACCUM;
          len_d   = base_len_s;
          count_d = base_count_s;
          if (sample_in_valid) begin
            max_d = new_max_s;
            min_d = new_min_s;
            if (done_s) begin
              state_d        = ST_REPORT;
              count_d        = '0;
              max_out_d      = new_max_s;
              min_out_d      = new_min_s;
              pp_out_d       = pp_s;
              result_valid_d = 1'b1;
            end else begin
              count_d = inc_count_s;
            end
          end else begin
            count_d = base_count_s;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      len_q          <= '0;
      max_q          <= '0;
      min_q          <= '0;
      max_out_q      <= '0;
      min_out_q      <= '0;
      pp_out_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      len_q          <= len_d;
      max_q          <= max_d;
      min_q          <= min_d;
      max_out_q      <= max_out_d;
      min_out_q      <= min_out_d;
      pp_out_q       <= pp_out_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign max_out      = max_out_q;
  assign min_out      = min_out_q;
  assign pp_out       = pp_out_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_window_peak_detector.sv
// Directed self-checking bench for window_peak_detector.
module tb_window_peak_detector;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] window_len;
  logic [15:0] sample_in;
  logic        sample_in_valid;
  logic [15:0] max_out;
  logic [15:0] min_out;
  logic [16:0] pp_out;
  logic        result_valid;
  logic        busy;

  int tests_run;
  int tests_failed;
  int pulses;

  window_peak_detector #(.word_width(16), .count_width(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .window_len      (window_len),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .max_out         (max_out),
    .min_out         (min_out),
    .pp_out          (pp_out),
    .result_valid    (result_valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one sample for one clock, then sit 1 time unit past the edge.
  task automatic send(input logic v, input logic [15:0] s);
    sample_in_valid = v;
    sample_in       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [15:0] mx,
                              input logic [15:0] mn, input logic [16:0] pp);
    check({tag, "_rv"},  64'(result_valid), 64'h1);
    check({tag, "_max"}, 64'(max_out), 64'(mx));
    check({tag, "_min"}, 64'(min_out), 64'(mn));
    check({tag, "_pp"},  64'(pp_out), 64'(pp));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; rst = 1'b0; enable = 1'b0; window_len = 32'd0;
    sample_in = 16'h0000; sample_in_valid = 1'b0;
    tests_run = 0; tests_failed = 0;

    // Reset state
    #3;
    check("rst_rv",   64'(result_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_max",  64'(max_out), 64'h0);
    check("rst_min",  64'(min_out), 64'h0);
    check("rst_pp",   64'(pp_out), 64'h0);
    @(posedge clk); #1;
    rst = 1'b1; enable = 1'b1; window_len = 32'd4;
    @(posedge clk); #1;
    check("accum_busy", 64'(busy), 64'h1);
    check("accum_rv",   64'(result_valid), 64'h0);

    // Basic window: 5,-3,7,2
    send(1'b1, 16'd5); send(1'b1, 16'hFFFD); send(1'b1, 16'd7);
    check("w1_early_rv", 64'(result_valid), 64'h0);
    send(1'b1, 16'd2);
    check_result("w1", 16'd7, 16'hFFFD, 17'd10);
    enable = 1'b0;
    send(1'b0, 16'h0000);
    check("w1_after_rv",   64'(result_valid), 64'h0);
    check("w1_after_busy", 64'(busy), 64'h0);
    check("w1_hold_max",   64'(max_out), 64'd7);

    // Gapped valid: 1,2,3,4 with bubbles
    enable = 1'b1; window_len = 32'd4;
    send(1'b0, 16'h0000);
    send(1'b1, 16'd1); send(1'b0, 16'h0055); send(1'b1, 16'd2); send(1'b0, 16'h0066);
    send(1'b1, 16'd3); send(1'b0, 16'h0077);
    check("w2_early_rv", 64'(result_valid), 64'h0);
    check("w2_hold_max", 64'(max_out), 64'd7);
    send(1'b1, 16'd4);
    check_result("w2", 16'd4, 16'd1, 17'd3);

    // Full scale, first sample taken during REPORT with re-latched length 2
    window_len = 32'd2;
    send(1'b1, 16'h7FFF);
    check("w3_early_rv", 64'(result_valid), 64'h0);
    send(1'b1, 16'h8000);
    check_result("w3", 16'h7FFF, 16'h8000, 17'h0FFFF);

    // Back-to-back windows of 3; length changes mid-window are ignored
    window_len = 32'd3;
    send(1'b1, 16'd10);
    window_len = 32'd7;
    send(1'b1, 16'd20);
    send(1'b1, 16'd30);
    check_result("w4", 16'd30, 16'd10, 17'd20);
    window_len = 32'd3;
    send(1'b1, 16'hFFCE);
    check("w5_first_rv", 64'(result_valid), 64'h0);
    window_len = 32'd7;
    send(1'b1, 16'hFFFA);
    send(1'b1, 16'd40);
    check_result("w5", 16'd40, 16'hFFCE, 17'd90);

    // Length 0 behaves as 1
    window_len = 32'd0;
    send(1'b1, 16'd9);
    check_result("len0_a", 16'd9, 16'd9, 17'd0);
    send(1'b1, 16'hFFFC);
    check_result("len0_b", 16'hFFFC, 16'hFFFC, 17'd0);
    send(1'b0, 16'h0000);
    check("len0_gap_rv", 64'(result_valid), 64'h0);
    send(1'b1, 16'd3);
    check_result("len0_c", 16'd3, 16'd3, 17'd0);

    // Abandon via enable after 2 of 4 samples
    window_len = 32'd4;
    send(1'b1, 16'd100);
    send(1'b1, 16'd200);
    enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 16'd300);
      if (result_valid) pulses++;
    end
    check("abandon_pulses", 64'(pulses), 64'd0);
    check("abandon_busy",   64'(busy), 64'h0);
    check("abandon_max",    64'(max_out), 64'd3);
    check("abandon_min",    64'(min_out), 64'd3);
    check("abandon_pp",     64'(pp_out), 64'd0);

    // Reset mid-window discards it
    enable = 1'b1; window_len = 32'd4;
    send(1'b0, 16'h0000);
    send(1'b1, 16'd50);
    send(1'b1, 16'd60);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_rv",   64'(result_valid), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_max",  64'(max_out), 64'h0);
    check("midrst_min",  64'(min_out), 64'h0);
    check("midrst_pp",   64'(pp_out), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    send(1'b0, 16'h0000);
    pulses = 0;
    send(1'b1, 16'd70);
    if (result_valid) pulses++;
    send(1'b1, 16'd80);
    if (result_valid) pulses++;
    send(1'b1, 16'd90);
    if (result_valid) pulses++;
    check("postrst_pulses", 64'(pulses), 64'd0);
    send(1'b1, 16'hFFFF);
    check_result("postrst", 16'd90, 16'hFFFF, 17'd91);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
